// File: rtl/gun_heat_tracker_if.sv
// rtl/gun_heat_tracker_if.sv - shooter/spawner-side signal bundle for gun_heat_tracker
interface gun_heat_tracker_if;
   logic       startGameEn;
   logic       shoot;
   logic       fire;
   logic [3:0] gun_cooldown;
   logic       overheated;

   modport master (
      output startGameEn,
      output shoot,
      input  fire,
      input  gun_cooldown,
      input  overheated
   );

   modport slave (
      input  startGameEn,
      input  shoot,
      output fire,
      output gun_cooldown,
      output overheated
   );
endinterface

// File: rtl/gun_heat_tracker.sv
// rtl/gun_heat_tracker.sv - rate-limited fire pulses with 4-bit heat and overheat lockout
module gun_heat_tracker #(
   parameter int SHOT_PERIOD = 5_000_000,
   parameter int COOL_PERIOD = 12_500_000
) (
   input  logic              clock,
   input  logic              reset,
   gun_heat_tracker_if.slave bus
);
   localparam int SW = $clog2(SHOT_PERIOD + 1);
   localparam int CW = $clog2(COOL_PERIOD + 1);
   localparam logic [SW-1:0] SHOT_RELOAD = SW'(SHOT_PERIOD - 1);
   localparam logic [CW-1:0] COOL_LAST   = CW'(COOL_PERIOD - 1);

   typedef enum logic {READY, LOCKOUT} state_t;

   state_t        state;
   logic [SW-1:0] shot_timer;
   logic [CW-1:0] cool_count;
   logic [3:0]    heat;
   logic          fire_q;
   logic          overheated_q;
   logic          fire_ok;

   assign fire_ok = (state == READY) && (shot_timer == '0) && bus.shoot;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= READY;
         shot_timer   <= '0;
         cool_count   <= '0;
         heat         <= 4'd0;
         fire_q       <= 1'b0;
         overheated_q <= 1'b0;
      end else if (bus.startGameEn) begin
         state        <= READY;
         shot_timer   <= '0;
         cool_count   <= '0;
         heat         <= 4'd0;
         fire_q       <= 1'b0;
         overheated_q <= 1'b0;
      end else if (fire_ok) begin
         // A shot restarts the cooling interval, so a coincident cool tick is lost.
         fire_q     <= 1'b1;
         heat       <= heat + 4'd1;
         shot_timer <= SHOT_RELOAD;
         cool_count <= '0;
         if (heat == 4'd14) begin
            state        <= LOCKOUT;
            overheated_q <= 1'b1;
         end
      end else begin
         fire_q <= 1'b0;
         if (shot_timer != '0)
            shot_timer <= shot_timer - SW'(1);
         if (heat == 4'd0) begin
            cool_count <= '0;
         end else if (cool_count == COOL_LAST) begin
            heat       <= heat - 4'd1;
            cool_count <= '0;
            if (heat == 4'd1) begin
               state        <= READY;
               overheated_q <= 1'b0;
            end
         end else begin
            cool_count <= cool_count + CW'(1);
         end
      end
   end

   assign bus.fire         = fire_q;
   assign bus.gun_cooldown = heat;
   assign bus.overheated   = overheated_q;
endmodule

// File: tb/tb_gun_heat_tracker.sv
// tb/tb_gun_heat_tracker.sv - scoreboard bench for gun_heat_tracker with SHOT_PERIOD=4, COOL_PERIOD=8
module tb_gun_heat_tracker;
   localparam int SP = 4;
   localparam int CP = 8;

   typedef struct packed {
      logic       fire;
      logic [3:0] heat;
      logic       ovh;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   gun_heat_tracker_if bus();

   gun_heat_tracker #(.SHOT_PERIOD(SP), .COOL_PERIOD(CP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model: shots and cool steps tracked as edge numbers of past events.
   int m_edge      = 0;
   int m_heat      = 0;
   int m_last_fire = -1000;
   int m_anchor    = 0;
   bit m_locked    = 1'b0;
   bit m_fire      = 1'b0;

   function automatic void model_edge(input bit s, input bit g, input bit r);
      m_edge++;
      if (r || g) begin
         m_heat      = 0;
         m_locked    = 1'b0;
         m_last_fire = -1000;
         m_fire      = 1'b0;
         return;
      end
      if (!m_locked && s && (m_edge - m_last_fire >= SP)) begin
         m_fire      = 1'b1;
         m_heat      = m_heat + 1;
         m_last_fire = m_edge;
         m_anchor    = m_edge;
         if (m_heat == 15) m_locked = 1'b1;
      end else begin
         m_fire = 1'b0;
         if (m_heat > 0 && (m_edge - m_anchor) == CP) begin
            m_heat   = m_heat - 1;
            m_anchor = m_edge;
            if (m_heat == 0) m_locked = 1'b0;
         end
      end
   endfunction

   task automatic cyc(input bit s, input bit g, input bit r);
      exp_t e;
      @(negedge clock);
      bus.shoot       = s;
      bus.startGameEn = g;
      if (r && !reset) begin
         reset = 1'b1;
         #1;
         checks++;
         if (bus.fire !== 1'b0 || bus.gun_cooldown !== 4'd0 || bus.overheated !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_clear: got fire=%0b heat=%0d ovh=%0b, want fire=0 heat=0 ovh=0",
                     bus.fire, bus.gun_cooldown, bus.overheated);
         end
      end else begin
         reset = r;
      end
      model_edge(s, g, r);
      e.fire = m_fire;
      e.heat = 4'(m_heat);
      e.ovh  = m_locked;
      exp_q.push_back(e);
   endtask

   exp_t want;
   exp_t got;

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = {bus.fire, bus.gun_cooldown, bus.overheated};
            checks++;
            if (got !== want) begin
               fails++;
               $display("FAIL outputs_t%0t: got fire=%0b heat=%0d ovh=%0b, want fire=%0b heat=%0d ovh=%0b",
                        $time, got.fire, got.heat, got.ovh, want.fire, want.heat, want.ovh);
            end
         end
      end
   end

   initial begin
      bus.shoot       = 1'b1;
      bus.startGameEn = 1'b0;

      // Reset held with shoot high, then continuous shooting into lockout and back out.
      repeat (3) cyc(1'b1, 1'b0, 1'b1);
      repeat (200) cyc(1'b1, 1'b0, 1'b0);
      repeat (40) cyc(1'b0, 1'b0, 1'b0);

      // Three shots then idle drain to zero.
      repeat (9) cyc(1'b1, 1'b0, 1'b0);
      repeat (40) cyc(1'b0, 1'b0, 1'b0);

      // Shot landing on the exact cool-tick edge at heat 2.
      repeat (5) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50 && (m_edge + 1 - m_anchor) != CP; i++)
         cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (30) cyc(1'b0, 1'b0, 1'b0);

      // startGameEn during lockout at heat 9.
      for (int i = 0; i < 100 && !m_locked; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200 && m_heat != 9; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);

      // Async reset while a fire pulse is high.
      repeat (6) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);

      // Randomised phases of held shoot, idle and toggling with rare clears.
      for (int p = 0; p < 80; p++) begin
         int ph;
         int len;
         ph  = $urandom_range(0, 9);
         len = $urandom_range(1, 80);
         for (int k = 0; k < len; k++) begin
            bit s;
            bit g;
            bit r;
            s = (ph < 5) ? 1'b1 : (ph < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            g = ($urandom_range(0, 199) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(s, g, r);
         end
      end
      cyc(1'b0, 1'b0, 1'b0);

      repeat (2) @(posedge clock);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/gun_heat_tracker.md
# gun_heat_tracker

Gun heat/rate controller that sits between a shooter (player input or enemy AI) and the projectile spawner. It converts a level-sensitive shoot request into rate-limited single-cycle fire pulses and maintains the 4-bit gun_cooldown heat value consumed by the gun handlers. Each shot adds heat, and idle time removes it. Reaching 4'hF forces an overheat lockout that lasts until the heat drains back to 4'h0.

## Interface
- SHOT_PERIOD, 5_000_000: minimum clock cycles between consecutive fire pulses (≥1; 10 shots/s at 50 MHz).
- COOL_PERIOD, 12_500_000: clock cycles per one-step heat decrement (≥1).
- clock  in  1  50 MHz system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- startGameEn  in  1  synchronous clear from the game FSM, same effect as reset at the next edge.
- shoot  in  1  level-sensitive shoot request.
- fire  out  1  one-cycle pulse; spawn one projectile.
- gun_cooldown  out  4  current heat, 0 (cold) to 15 (overheated).
- overheated  out  1  high during the lockout.

## Operation
- Reset and startGameEn values: fire=0, gun_cooldown=0, overheated=0, shot timer=0, cool counter=0, state READY.
- Timers:
  - Shot timer is a down-counter of width $clog2(SHOT_PERIOD+1).
  - Cool counter is an up-counter of width $clog2(COOL_PERIOD+1).
- States:
  - READY (overheated=0).
  - LOCKOUT (overheated=1).
- Fire condition, evaluated at each edge: state READY, shot timer==0, shoot==1, startGameEn==0.
- On fire:
  - fire=1 for exactly one cycle.
  - gun_cooldown increments by 1.
  - Shot timer loads SHOT_PERIOD-1.
  - Cool counter clears to 0.
- Shot timer decrements by 1 per cycle while nonzero, in either state.
- Cooling: on any edge without fire where gun_cooldown≠0:
  - If cool counter==COOL_PERIOD-1: gun_cooldown decrements and the counter returns to 0.
  - Otherwise the counter increments.
- When gun_cooldown==0 the cool counter holds at 0.
- READY→LOCKOUT: on the fire that takes gun_cooldown from 14 to 15. overheated rises on the same edge.
- LOCKOUT:
  - shoot is ignored and no fire is issued.
  - Cooling continues at COOL_PERIOD.
- LOCKOUT→READY: on the edge where gun_cooldown decrements from 1 to 0. overheated falls on that edge.
  - A fire is possible on the following edge if shoot is high and the shot timer is 0.
- Heat never wraps:
  - The increment only happens from values ≤14.
  - 15 can only be reached by entering LOCKOUT.
  - The decrement never goes below 0.
- Simultaneous fire and cool tick: fire wins, heat goes +1 (no net 0), cool counter clears.
- startGameEn has priority over fire and cooling. reset has priority over everything.

## Timing
- All outputs are registered and change only on clock edges (or asynchronously on reset).
- Shoot→fire latency:
  - shoot sampled high at edge N (conditions met) → fire=1 during cycle N..N+1.
  - gun_cooldown shows the new value from edge N.
- Held shoot: fire pulses every SHOT_PERIOD cycles. With SHOT_PERIOD=1, fire is high every cycle.
- After the last fire, the first decrement occurs COOL_PERIOD edges later, then every COOL_PERIOD edges.
- Full lockout drain from 15: 15×COOL_PERIOD cycles after the overheating fire.
- Reset asserted mid-lockout or mid-pulse: outputs go to reset values immediately. The first fire is possible at the first edge after deassertion with shoot high.

## Test plan
All scenarios use SHOT_PERIOD=4, COOL_PERIOD=8.
1. Apply reset while shoot=1 → fire=0, gun_cooldown=0, overheated=0 throughout. Release reset → fire at the first edge, gun_cooldown=1.
2. Hold shoot 20 cycles from cold → fire at edges 0,4,8,12,16; gun_cooldown 1,2,3,4,5; no decrement (each fire clears cool counter).
3. Hold shoot until 15 fires → gun_cooldown=F and overheated=1 on the 15th fire edge. No further fire while shoot stays high. gun_cooldown steps E,D,…,0 every 8 cycles. overheated falls at 0 after 120 cycles. Fire resumes on the next edge.
4. Three fires then release shoot → gun_cooldown 3→2→1→0 at 8, 16, 24 cycles after the last fire, then holds at 0 with no underflow.
5. shoot asserted on the exact edge where the cool counter would tick (heat=2) → fire=1, gun_cooldown=3, cool counter 0. The next decrement is 8 cycles later.
6. startGameEn pulsed mid-lockout at gun_cooldown=9 → next edge gun_cooldown=0, overheated=0, fire=0. Async reset mid-pulse clears fire within the same cycle.
